qos_wrr_scheduler: RTL and testbench
====================================

# qos_wrr_scheduler

Weighted round-robin scheduler for the PCIe QoS path. It arbitrates between NUM_Q per-traffic-class queue FIFOs and issues one-hot pop strobes. It drives the load/hold select and the enable of the downstream translation register stage, so each popped word is captured exactly once. Each class receives up to its programmed weight of pops per round, and the scheduler stalls on downstream back-pressure.

## Interface
- NUM_Q, 4, number of queues (power of two, 2..8)
- WEIGHT_W, 4, width of each per-queue weight and credit counter
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- enb  in  1  global enable; 0 stalls scheduling with all state held
- empty  in  NUM_Q  per-queue FIFO empty flags
- weight  in  NUM_Q*WEIGHT_W  per-queue weight, queue i at bits [i*WEIGHT_W +: WEIGHT_W]; 0 disables the queue
- down_afull  in  1  downstream almost-full; blocks pops
- pop  out  NUM_Q  one-hot FIFO read strobe; combinational from registered state and current inputs
- grant_id  out  log2(NUM_Q)  index of the queue whose word is valid this cycle (registered)
- valid_out  out  1  popped word present on the FIFO read bus (FIFO read latency is 1)
- sel_hold  out  1  translation-stage select: 0 = load, 1 = hold; always the inverse of valid_out
- idle  out  1  scheduler in IDLE

## Operation
- State: FSM {IDLE, RELOAD, SERVE}, pointer ptr, credit[i] (WEIGHT_W bits each).
- Eligible(i) = !empty[i] && weight[i]!=0. Serveable(i) = !empty[i] && credit[i]!=0.
- stall = !enb || down_afull. While stalled, no state, pointer or credit changes occur.
- IDLE: when any queue is Eligible, go to RELOAD. Otherwise stay.
- RELOAD: credit[i] <= weight[i] for all i. Go to SERVE. Weights are sampled only here; changes mid-round apply at the next reload.
- SERVE, not stalled:
  - pop[ptr] = Serveable(ptr). On a pop, credit[ptr] is decremented.
  - If credit[ptr] is still nonzero after the cycle and empty[ptr]=0, ptr holds and pops continue back-to-back.
  - Otherwise, search circularly from ptr+1 using post-decrement credits:
    - If a Serveable queue is found, ptr moves to it.
    - Else, if any queue is Eligible: go to RELOAD, with ptr <= (ptr+1) mod NUM_Q.
    - Else: go to IDLE, ptr unchanged.
- Pop with empty=1 never occurs. A stale empty after the last word causes at most one bubble cycle.
- Credits only decrement from nonzero, so no wrap-around is possible.

## Timing
- Reset values (next edge with reset=1): state=IDLE, ptr=0, all credits=0, pop=0, valid_out=0, grant_id=0, sel_hold=1, idle=1.
- Reset overrides everything, including mid-burst. A pop pending in the reset cycle is suppressed, because state becomes IDLE.
- Startup latency: first queue goes non-empty in cycle N (IDLE) → RELOAD in N+1 → first pop in N+2.
- valid_out and grant_id in cycle k+1 reflect the pop in cycle k. sel_hold=0 in exactly those cycles.
- A RELOAD between rounds costs one cycle with no pop.
- down_afull acts in the same cycle: pop=0 while it is asserted.

## Configuration
- QOS_STRICT_PRIO_EN defined: queue 0 has strict priority.
  - In SERVE, when not stalled and empty[0]=0, pop[0]=1 regardless of ptr or credit[0].
  - Neither ptr nor any credit changes on such a pop; WRR resumes at the same ptr once queue 0 is empty.
  - IDLE treats !empty[0] as Eligible even when weight[0]=0.
- Undefined: queue 0 is an ordinary WRR participant.

## Test plan
- Reset: hold reset 3 cycles with all queues non-empty → pop=0, valid_out=0, sel_hold=1, idle=1, grant_id=0; first pop 2 cycles after reset drops.
- Weights {3,1,1,1}, all queues always non-empty → pops q0,q0,q0,q1,q2,q3, one bubble, q0… repeating. grant_id trails pop by one cycle.
- Same setup, down_afull=1 for 2 cycles after the second q0 pop → pop=0 for 2 cycles, then exactly one more q0 pop before q1.
- Weights {2,0,2,2}, only q1 non-empty → stays IDLE, pop never asserted. Then q3 non-empty → q3 popped twice per round.
- Reset asserted during the q2 pop cycle → pop=0 in that cycle, IDLE next cycle, ptr=0, credits cleared.
- With QOS_STRICT_PRIO_EN, weights {1,2,2,2}: q0 made non-empty for one word during q2's turn → q0 popped next cycle, then q2 resumes with its credit unchanged.

Source files
------------

// File: rtl/qos_wrr_scheduler.sv
// qos_wrr_scheduler
// Weighted round-robin scheduler for the PCIe QoS path. Arbitrates between
// NUM_Q traffic-class FIFOs, issuing one-hot pop strobes, and steers the
// downstream translation register stage (load/hold) so each popped word is
// captured exactly once. Each class receives up to its weight of pops per
// round; scheduling stalls on !enb or down_afull.
//
// Optional build macro: QOS_STRICT_PRIO_EN -- queue 0 gets strict priority
// over the WRR rotation (it does not consume credit or move the pointer).
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   enb        global enable; 0 holds all state
//   empty      per-queue FIFO empty flags
//   weight     per-queue weights, queue i at [i*WEIGHT_W +: WEIGHT_W]; 0 disables
//   down_afull downstream almost-full; blocks pops in the same cycle
//   pop        one-hot FIFO read strobe (combinational)
//   grant_id   queue index of the word valid this cycle (registered)
//   valid_out  popped word present on the FIFO read bus
//   sel_hold   translation-stage select, 0 = load, 1 = hold (= ~valid_out)
//   idle       scheduler in IDLE
//
// state  | meaning
// IDLE   | no eligible queue seen; waiting for work
// RELOAD | load credits from weights (one cycle, no pop)
// SERVE  | pop the queue at ptr while it has credit and data

module qos_wrr_scheduler #(
   parameter int NUM_Q    = 4,
   parameter int WEIGHT_W = 4,
   localparam int PW      = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enb,
   input  logic [NUM_Q-1:0]          empty,
   input  logic [NUM_Q*WEIGHT_W-1:0] weight,
   input  logic                      down_afull,
   output logic [NUM_Q-1:0]          pop,
   output logic [PW-1:0]             grant_id,
   output logic                      valid_out,
   output logic                      sel_hold,
   output logic                      idle
);

   typedef enum logic [1:0] {S_IDLE, S_RELOAD, S_SERVE} state_t;

   state_t              state, state_nxt;
   logic [PW-1:0]       ptr, ptr_nxt;
   logic [WEIGHT_W-1:0] credit     [NUM_Q];
   logic [WEIGHT_W-1:0] credit_nxt [NUM_Q];
   logic [NUM_Q-1:0]    eligible;
   logic                stall;
   logic                any_elig;
   logic                strict_pop;
   logic                found;
   logic [PW-1:0]       cand;
   logic [PW-1:0]       pop_idx;

   always_comb begin
      stall = !enb || down_afull;
      for (int i = 0; i < NUM_Q; i++) begin
         eligible[i] = !empty[i] && (weight[i*WEIGHT_W +: WEIGHT_W] != '0);
      end
`ifdef QOS_STRICT_PRIO_EN
      eligible[0] = !empty[0];
      strict_pop  = (state == S_SERVE) && !stall && !empty[0];
`else
      strict_pop  = 1'b0;
`endif
      any_elig = |eligible;
   end

   always_comb begin
      pop        = '0;
      state_nxt  = state;
      ptr_nxt    = ptr;
      credit_nxt = credit;
      found      = 1'b0;
      cand       = ptr;
      if (!stall) begin
         case (state)
            S_IDLE: begin
               if (any_elig) state_nxt = S_RELOAD;
            end
            S_RELOAD: begin
               for (int i = 0; i < NUM_Q; i++) begin
                  credit_nxt[i] = weight[i*WEIGHT_W +: WEIGHT_W];
               end
               state_nxt = S_SERVE;
            end
            S_SERVE: begin
               if (strict_pop) begin
                  // priority pop leaves the WRR round untouched
                  pop[0] = 1'b1;
               end else begin
                  if (!empty[ptr] && (credit[ptr] != '0)) begin
                     pop[ptr]        = 1'b1;
                     credit_nxt[ptr] = credit[ptr] - WEIGHT_W'(1);
                  end
                  if (!((credit_nxt[ptr] != '0) && !empty[ptr])) begin
                     // ptr itself cannot be serveable here, so NUM_Q-1 probes suffice
                     for (int k = 1; k < NUM_Q; k++) begin
                        cand = ptr + PW'(k);
                        if (!found && !empty[cand] && (credit_nxt[cand] != '0)) begin
                           found   = 1'b1;
                           ptr_nxt = cand;
                        end
                     end
                     if (!found) begin
                        if (any_elig) begin
                           state_nxt = S_RELOAD;
                           ptr_nxt   = ptr + PW'(1);
                        end else begin
                           state_nxt = S_IDLE;
                        end
                     end
                  end
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
      // a pop in the reset cycle would lose its word, since valid_out is cleared
      if (reset) pop = '0;
   end

   assign pop_idx = strict_pop ? '0 : ptr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         ptr       <= '0;
         valid_out <= 1'b0;
         grant_id  <= '0;
         for (int i = 0; i < NUM_Q; i++) credit[i] <= '0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         credit    <= credit_nxt;
         valid_out <= |pop;
         if (|pop) grant_id <= pop_idx;
      end
   end

   assign sel_hold = ~valid_out;
   assign idle     = (state == S_IDLE);

endmodule

// File: tb/tb_qos_wrr_scheduler.sv
module tb_qos_wrr_scheduler;

   localparam int NQ = 4;
   localparam int WW = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            enb;
   logic [NQ-1:0]   empty;
   logic [NQ*WW-1:0] weight;
   logic            down_afull;
   logic [NQ-1:0]   pop;
   logic [1:0]      grant_id;
   logic            valid_out;
   logic            sel_hold;
   logic            idle;

   qos_wrr_scheduler #(.NUM_Q(NQ), .WEIGHT_W(WW)) dut (
      .clk(clk), .reset(reset), .enb(enb), .empty(empty), .weight(weight),
      .down_afull(down_afull), .pop(pop), .grant_id(grant_id),
      .valid_out(valid_out), .sel_hold(sel_hold), .idle(idle)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

`ifdef QOS_STRICT_PRIO_EN
   localparam bit STRICT = 1'b1;
`else
   localparam bit STRICT = 1'b0;
`endif

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // reference model: mode 0=idle 1=reload 2=serve
   int m_mode = 0;
   int m_ptr  = 0;
   int m_cred [NQ];
   int m_grant = 0;
   int last_pop;

   typedef struct { bit v; bit rst; int g; } exp_t;
   exp_t sbq[$];
   bit   mon_en = 0;

   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (sbq.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("valid_out", int'(valid_out), int'(e.v));
            chk("sel_hold", int'(sel_hold), int'(!e.v));
            if (e.v || e.rst) chk("grant_id", int'(grant_id), e.g);
         end
      end
   end

   function automatic int decode(input logic [NQ-1:0] p);
      if (p == '0) return -1;
      if (!$onehot(p)) return -2;
      for (int i = 0; i < NQ; i++) if (p[i]) return i;
      return -2;
   endfunction

   task automatic cyc(input bit rst, input bit en, input bit af,
                      input logic [NQ-1:0] emp, input logic [NQ*WW-1:0] wt);
      int  w [NQ];
      bit  el [NQ];
      bit  any_el;
      int  exp_pop;
      bit  found;
      exp_t e;
      @(negedge clk);
      reset = rst; enb = en; down_afull = af; empty = emp; weight = wt;
      #1;
      any_el = 0;
      for (int i = 0; i < NQ; i++) begin
         w[i]  = int'(wt[i*WW +: WW]);
         el[i] = !emp[i] && (w[i] != 0 || (STRICT && i == 0));
         if (el[i]) any_el = 1;
      end
      exp_pop = -1;
      chk("idle", int'(idle), int'(m_mode == 0));
      if (rst) begin
         m_mode = 0; m_ptr = 0; m_grant = 0;
         for (int i = 0; i < NQ; i++) m_cred[i] = 0;
      end else if (en && !af) begin
         if (m_mode == 0) begin
            if (any_el) m_mode = 1;
         end else if (m_mode == 1) begin
            for (int i = 0; i < NQ; i++) m_cred[i] = w[i];
            m_mode = 2;
         end else if (STRICT && !emp[0]) begin
            exp_pop = 0;
         end else begin
            if (!emp[m_ptr] && m_cred[m_ptr] > 0) begin
               exp_pop = m_ptr;
               m_cred[m_ptr]--;
            end
            if (!(m_cred[m_ptr] > 0 && !emp[m_ptr])) begin
               found = 0;
               for (int k = 1; k < NQ && !found; k++) begin
                  int j;
                  j = (m_ptr + k) % NQ;
                  if (!emp[j] && m_cred[j] > 0) begin
                     found = 1; m_ptr = j;
                  end
               end
               if (!found) begin
                  if (any_el) begin
                     m_mode = 1; m_ptr = (m_ptr + 1) % NQ;
                  end else begin
                     m_mode = 0;
                  end
               end
            end
         end
         if (exp_pop >= 0) m_grant = exp_pop;
      end
      last_pop = decode(pop);
      chk("pop", last_pop, exp_pop);
      e.v = (exp_pop >= 0); e.rst = rst; e.g = m_grant;
      sbq.push_back(e);
      mon_en = 1;
   endtask

   localparam logic [15:0] W3111 = 16'h1113;
   localparam logic [15:0] W2022 = 16'h2202;
   localparam logic [15:0] W1222 = 16'h2221;

   int seq_a [16] = '{-1,-1,0,0,0,1,2,3,-1,0,0,0,1,2,3,-1};
   int seq_b [10] = '{-1,-1,0,0,-1,-1,0,1,2,3};
   int seq_c [10] = '{-1,-1,0,0,0,1,-1,-1,-1,0};
   int seq_d [9]  = '{-1,-1,-1,3,3,-1,-1,3,3};
   int seq_e [10] = '{-1,-1,-1,1,1,2,0,2,3,3};

   initial begin
      logic [15:0] wr;
      logic [3:0]  er;
      reset = 1'b1; enb = 1'b1; down_afull = 1'b0; empty = '1; weight = '0;
      for (int i = 0; i < NQ; i++) m_cred[i] = 0;

      // reset held 3 cycles with all queues non-empty
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 0, 4'h0, W3111);
         chk("reset_pop", last_pop, -1);
      end
`ifndef QOS_STRICT_PRIO_EN
      for (int i = 0; i < 16; i++) begin
         cyc(0, 1, 0, 4'h0, W3111);
         chk("seq_3111", last_pop, seq_a[i]);
      end
      cyc(1, 1, 0, 4'h0, W3111);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1, (i == 4 || i == 5), 4'h0, W3111);
         chk("seq_afull", last_pop, seq_b[i]);
      end
      cyc(1, 1, 0, 4'h0, W3111);
      for (int i = 0; i < 10; i++) begin
         cyc(i == 6, 1, 0, 4'h0, W3111);
         chk("seq_reset_q2", last_pop, seq_c[i]);
         if (i == 6) chk("idle_after_reset", int'(idle), 0);
         if (i == 7) chk("idle_after_reset", int'(idle), 1);
      end
`endif
      cyc(1, 1, 0, 4'hF, W2022);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 1, 0, 4'b1101, W2022);
         chk("only_q1_idle", last_pop, -1);
         chk("only_q1_idle_flag", int'(idle), 1);
      end
      for (int i = 0; i < 9; i++) begin
         cyc(0, 1, 0, 4'b0101, W2022);
         chk("seq_2022", last_pop, seq_d[i]);
      end
`ifdef QOS_STRICT_PRIO_EN
      cyc(1, 1, 0, 4'hF, W1222);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1, 0, (i == 6) ? 4'b0000 : 4'b0001, W1222);
         chk("seq_strict", last_pop, seq_e[i]);
      end
`endif

      // randomized phase against the reference model
      wr = W3111;
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 19) == 0) begin
            for (int i = 0; i < NQ; i++) wr[i*WW +: WW] = WW'($urandom_range(0, 4));
         end
         for (int i = 0; i < NQ; i++) er[i] = ($urandom_range(0, 9) < 3);
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
             $urandom_range(0, 4) == 0, er, wr);
      end

      @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
